// File: rtl/alu_pkg.sv
// Shared ALU definitions: the opcode encoding, the number of legal opcodes
// and the default datapath width. Imported by the ALU and by the arbiter.
package alu_pkg;

  // Operand/result width the ALU datapath is built for. SLT, SLTU and SRA
  // are written for exactly this width.
  localparam int DATA_WIDTH_DEFAULT = 32;

  // Number of legal opcode encodings (AddOp .. SraOp).
  localparam int NUM_OPS = 10;

  // Opcode encoding as driven by decode and by the address/PC path.
  typedef enum logic [3:0] {
    AddOp  = 4'd0,
    SubOp  = 4'd1,
    AndOp  = 4'd2,
    OrOp   = 4'd3,
    XorOp  = 4'd4,
    SltOp  = 4'd5,
    SltuOp = 4'd6,
    SllOp  = 4'd7,
    SrlOp  = 4'd8,
    SraOp  = 4'd9
  } ALU_Ops;

  // True when a raw 4-bit opcode is one of the NUM_OPS legal encodings.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (int'(op) < NUM_OPS);
  endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational ALU. Illegal opcodes return zero and flag err_o so
// that the result is always a defined value.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [3:0]            op_i,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic                  err_o
);

  // Shift amount uses only the low five bits of operand B.
  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Opcode decode and datapath select.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    y_o   = '0;
    err_o = !op_is_legal(op_i);
    case (op_i)
      AddOp:   y_o = a_i + b_i;
      SubOp:   y_o = a_i - b_i;
      AndOp:   y_o = a_i & b_i;
      OrOp:    y_o = a_i | b_i;
      XorOp:   y_o = a_i ^ b_i;
      SltOp:   y_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      SltuOp:  y_o = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
      SllOp:   y_o = a_i << shamt;
      SrlOp:   y_o = a_i >> shamt;
      SraOp:   y_o = $unsigned($signed(a_i) >>> shamt);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. On a tie the requester that did not win the
// last transfer is granted; a lone requester is always granted.
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot grant from the request pair and the previous winner.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the execute stage (requester 0) and the
// address/PC-generation path (requester 1). The winner's operands go
// through a single ALU into one output register tagged with the owner id.
// DATA_WIDTH must stay at 32: the ALU's compare and arithmetic-shift logic
// is written for that width.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  reset_i,

  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  input  logic [3:0]            req0_op_i,

  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  input  logic [3:0]            req1_op_i,

  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_y_o,
  output logic                  rsp_id_o,
  output logic                  rsp_err_o
);

  // Output register and arbitration history.
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_y_q,     rsp_y_d;
  logic                  rsp_id_q,    rsp_id_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic                  last_grant_q, last_grant_d;

  logic [1:0]            grant;
  logic                  can_accept;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic [3:0]            sel_op;
  logic [DATA_WIDTH-1:0] alu_y;
  logic                  alu_err;

  rr_arbiter2 u_rr_arbiter2 (
    .valid_i      ({req1_valid_i, req0_valid_i}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // The register can take a new result when it is empty or being drained
  // this cycle. Ready is a function of grant and downstream state only,
  // never of the requester's own ready.
  assign can_accept   = !rsp_valid_q || rsp_ready_i;
  assign req0_ready_o = grant[0] && can_accept;
  assign req1_ready_o = grant[1] && can_accept;
  assign xfer         = (req0_valid_i && req0_ready_o) ||
                        (req1_valid_i && req1_ready_o);

  // Operand mux: route the granted requester's operands to the ALU.
  always_comb begin
    sel_a  = req0_a_i;
    sel_b  = req0_b_i;
    sel_op = req0_op_i;
    if (grant[1]) begin
      sel_a  = req1_a_i;
      sel_b  = req1_b_i;
      sel_op = req1_op_i;
    end
  end

  alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .a_i   (sel_a),
    .b_i   (sel_b),
    .op_i  (sel_op),
    .y_o   (alu_y),
    .err_o (alu_err)
  );

  // Next-state for the output register: load on transfer, clear valid on a
  // drain with nothing new, otherwise hold everything.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_y_d      = rsp_y_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      rsp_valid_d  = 1'b1;
      rsp_y_d      = alu_y;
      rsp_id_d     = grant[1];
      rsp_err_d    = alu_err;
      last_grant_d = grant[1];
    end else if (rsp_ready_i) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // State registers. last_grant resets to 1 so requester 0 wins the first
  // tie; every flop here is a small control/data register and takes reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rsp_valid_q  <= 1'b0;
      rsp_y_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its _d input, independent of statement order.
      rsp_valid_q  <= rsp_valid_d;
      rsp_y_q      <= rsp_y_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_y_o     = rsp_y_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
